// File: rtl/axis_packet_source_if.sv
// AXI-Stream bundle for the packet source: master drives the beat, slave returns TREADY.
interface axis_packet_source_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2
);
    logic              tvalid;
    logic              tready;
    logic [TDATAW-1:0] tdata;
    logic              tlast;
    logic [TIDW-1:0]   tid;
    logic [TDESTW-1:0] tdest;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tid,
        output tdest,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tid,
        input  tdest,
        output tready
    );
endinterface

// File: rtl/axis_packet_source.sv
// Synthetic AXI-Stream traffic generator: on START emits NUM packets of LEN beats whose
// data encodes {packet index, beat index}; DONE is sticky until the next accepted START.
module axis_packet_source #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2,
    parameter int LENW   = 8,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNTW-1:0]   cfg_num_pkts_i,
    input  logic [LENW-1:0]   cfg_len_i,
    input  logic [TDESTW-1:0] cfg_dest_i,
    input  logic              cfg_dest_inc_i,
    input  logic [TIDW-1:0]   cfg_id_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNTW-1:0]   pkt_cnt_o,
    axis_packet_source_if.master axis_m
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam int HALFW = TDATAW / 2;

    logic [0:0]        state_q, state_d;
    logic [CNTW-1:0]   num_q, num_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [TDESTW-1:0] dest_q, dest_d;
    logic              dest_inc_q, dest_inc_d;
    logic [TIDW-1:0]   id_q, id_d;
    logic [CNTW-1:0]   pkt_idx_q, pkt_idx_d;
    logic [LENW-1:0]   beat_idx_q, beat_idx_d;
    logic              done_q, done_d;
    logic              tvalid_q, tvalid_d;
    logic [TDATAW-1:0] tdata_q, tdata_d;
    logic              tlast_q, tlast_d;

    logic              handshake;
    logic [HALFW-1:0]  pkt_field;
    logic [HALFW-1:0]  beat_field;

    assign handshake = tvalid_q && axis_m.tready;

    // Both data halves wrap modulo 2^(TDATAW/2) regardless of the counter widths.
    generate
        if (CNTW >= HALFW) begin : g_pkt_trunc
            assign pkt_field = pkt_idx_d[HALFW-1:0];
        end else begin : g_pkt_ext
            assign pkt_field = {{(HALFW-CNTW){1'b0}}, pkt_idx_d};
        end
        if (LENW >= HALFW) begin : g_beat_trunc
            assign beat_field = beat_idx_d[HALFW-1:0];
        end else begin : g_beat_ext
            assign beat_field = {{(HALFW-LENW){1'b0}}, beat_idx_d};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        len_d      = len_q;
        dest_d     = dest_q;
        dest_inc_d = dest_inc_q;
        id_d       = id_q;
        pkt_idx_d  = pkt_idx_q;
        beat_idx_d = beat_idx_q;
        done_d     = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    num_d      = cfg_num_pkts_i;
                    len_d      = (cfg_len_i == '0) ? LENW'(1) : cfg_len_i;
                    dest_d     = cfg_dest_i;
                    dest_inc_d = cfg_dest_inc_i;
                    id_d       = cfg_id_i;
                    pkt_idx_d  = '0;
                    beat_idx_d = '0;
                    // An empty run completes immediately without leaving IDLE.
                    done_d     = (cfg_num_pkts_i == '0);
                    state_d    = (cfg_num_pkts_i == '0) ? ST_IDLE : ST_SEND;
                end
            end
            default: begin
                if (handshake) begin
                    if (tlast_q) begin
                        pkt_idx_d  = pkt_idx_q + CNTW'(1);
                        beat_idx_d = '0;
                        if (dest_inc_q) begin
                            dest_d = dest_q + TDESTW'(1);
                        end
                        if (pkt_idx_q == num_q - CNTW'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + LENW'(1);
                    end
                end
            end
        endcase

        // Beat outputs are precomputed from next state so they appear registered.
        tvalid_d = (state_d == ST_SEND);
        tdata_d  = {pkt_field, beat_field};
        tlast_d  = tvalid_d && (beat_idx_d == len_d - LENW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            len_q      <= '0;
            dest_q     <= '0;
            dest_inc_q <= 1'b0;
            id_q       <= '0;
            pkt_idx_q  <= '0;
            beat_idx_q <= '0;
            done_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            len_q      <= len_d;
            dest_q     <= dest_d;
            dest_inc_q <= dest_inc_d;
            id_q       <= id_d;
            pkt_idx_q  <= pkt_idx_d;
            beat_idx_q <= beat_idx_d;
            done_q     <= done_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
        end
    end

    // Packet index counts completed packets, so it doubles as PKT_CNT.
    assign busy_o       = (state_q == ST_SEND);
    assign done_o       = done_q;
    assign pkt_cnt_o    = pkt_idx_q;
    assign axis_m.tvalid = tvalid_q;
    assign axis_m.tdata  = tdata_q;
    assign axis_m.tlast  = tlast_q;
    assign axis_m.tid    = id_q;
    assign axis_m.tdest  = dest_q;
endmodule
